mux2to1_arbiter: RTL
====================

Name: mux2to1_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 2:1 mux output path between two requesters.
- Each requester presents data and a request. The block grants one requester at a time, in bursts of up to MAX_BURST beats.
- It drives the mux select and captures the selected word into a registered output stage with a valid/ready handshake.
- It sits between two producer blocks and a single downstream consumer.

Parameters:
- WIDTH, 8, data width of each mux input and of the output.
- MAX_BURST, 4, maximum beats accepted from one requester per grant; range 1..15.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- resetn  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- req  input  2  req[i] high means requester i has a valid word on wi.
- w0  input  WIDTH  data from requester 0.
- w1  input  WIDTH  data from requester 1.
- out_ready  input  1  downstream can accept f this cycle.
- gnt  output  2  one-hot current grant; 2'b00 when idle.
- ack  output  2  ack[i] high means the word on wi is accepted at this clock edge (combinational).
- s  output  1  mux select; 0 selects w0, 1 selects w1.
- f  output  WIDTH  registered output word.
- f_valid  output  1  f holds an undelivered word.
- burst_cnt  output  4  beats accepted in the current grant.

Behaviour:
- Reset (resetn low at an edge):
  - state IDLE, gnt 00, s 0, f 0, f_valid 0, burst_cnt 0, internal last_served 1, so requester 0 wins first.
  - Reset mid-burst discards any held word and the grant. No ack is asserted in the cycle resetn is low.
- States: IDLE, GRANT0, GRANT1.
  - gnt = 01 in GRANT0, 10 in GRANT1, 00 in IDLE.
  - s = 1 only in GRANT1; otherwise s holds its last value (0 after reset).
- Output stage:
  - space = !f_valid | out_ready.
  - ack[i] = gnt[i] & req[i] & space.
  - On an edge with any ack: f <= selected word, f_valid <= 1, burst_cnt increments.
  - On an edge with f_valid & out_ready and no ack: f_valid <= 0 and f holds its value.
  - Simultaneous drain and accept keeps f_valid at 1 at full throughput, one beat per cycle.
- Latency:
  - req rising in IDLE produces a grant on the next edge; the first ack is possible one cycle after req is first sampled.
  - A word acked at edge k is on f with f_valid high from the cycle after edge k.
- IDLE transitions:
  - Only req[0]: go to GRANT0.
  - Only req[1]: go to GRANT1.
  - Both: grant the requester not equal to last_served.
  - None: stay in IDLE.
- GRANTi release condition: burst_cnt reaches MAX_BURST after an ack, OR req[i] is low at an edge.
  - On release: last_served <= i and burst_cnt <= 0.
  - Next state: GRANT(other) if req[other] is high; else GRANTi (new burst) if req[i] is high; else IDLE.
  - The grant switch takes effect the cycle after release. No ack is issued to the new owner in the release cycle.
- Backpressure:
  - While out_ready is low and f_valid is high, ack stays low and burst_cnt holds.
  - The grant is not revoked for stalling; it is revoked only by the release conditions above.
- A requester that drops req mid-burst loses the grant. The beats it already delivered count toward fairness (last_served updates).
- burst_cnt never exceeds MAX_BURST and saturates at release.

Test Plan:
1. Reset, then req=01, w0=0x11, out_ready=1 held: gnt=01 the next cycle; f=0x11 with f_valid=1 one cycle after the first ack; burst_cnt reaches 4, then GRANT0 re-enters with burst_cnt=0.
2. req=11 held, w0=0xA0, w1=0xB0, out_ready=1: first burst is 4 beats from requester 0 (s=0), then 4 beats from requester 1 (s=1); alternation continues; no cycle has two ack bits high.
3. Backpressure: in GRANT1 with f_valid=1, out_ready=0 for 3 cycles: ack=00, f and burst_cnt frozen; when out_ready=1, delivery and acceptance resume at one beat per cycle.
4. Early release: GRANT0 after 2 beats, req[0] drops while req[1]=1: GRANT1 on the next edge, burst_cnt=0, last_served=0.
5. Reset mid-burst: resetn=0 for one edge during GRANT1 with f_valid=1: gnt=00, f=0, f_valid=0, burst_cnt=0; with req=11 afterwards, requester 0 wins.
6. MAX_BURST=1 build, req=11: grant alternates every accepted beat, with one bubble cycle between bursts.

Source files
------------

// File: rtl/mux2to1_arbiter.sv
// mux2to1_arbiter
//   Round-robin arbiter that shares one 2:1 mux path between two requesters
//   and captures the selected word into a one-entry registered output stage.
//   A requester keeps the grant for up to MAX_BURST accepted beats. It can also
//   drop the grant early by lowering req. Ownership then passes to the other
//   requester if it is waiting.
//
// Ports
//   clk        system clock, rising edge
//   resetn     synchronous active-low reset
//   req[1:0]   req[i] high: requester i presents a valid word on wi
//   w0, w1     requester data words
//   out_ready  downstream accepts f this cycle
//   gnt[1:0]   one-hot grant, 2'b00 when idle (this is also the FSM state)
//   ack[1:0]   ack[i] high: word on wi is taken at this edge (combinational)
//   s          mux select, 0 = w0, 1 = w1
//   f          registered output word
//   f_valid    f holds an undelivered word
//   burst_cnt  beats accepted in the current grant
//
// Handshakes
//   Upstream: a beat from requester i transfers on an edge where req[i] and
//   ack[i] are both high. Downstream: f transfers on an edge where f_valid and
//   out_ready are both high. Once valid is raised, it stays high and the data
//   stays stable until the transfer.

module mux2to1_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] w0,
  input  logic [WIDTH-1:0] w1,
  input  logic             out_ready,
  output logic [1:0]       gnt,
  output logic [1:0]       ack,
  output logic             s,
  output logic [WIDTH-1:0] f,
  output logic             f_valid,
  output logic [3:0]       burst_cnt
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  // The state codes are the grant vector, so gnt exposes the FSM state directly.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic             s_q;
  logic [WIDTH-1:0] f_q;
  logic             f_valid_q;
  logic [3:0]       burst_cnt_q;
  logic             last_served_q;

  logic             space;
  logic             room;
  logic             release_grant;

  // The output stage can take a word if it is empty or is draining this edge.
  // A grant that has reached MAX_BURST spends one cycle releasing. No beat is
  // accepted in that cycle, which produces the bubble between bursts.
  always_comb begin
    space = !f_valid_q | out_ready;
    room  = (burst_cnt_q != MAX_CNT);
    ack   = 2'b00;
    if (resetn && space && room) begin
      ack = state_q & req;
    end
  end

  always_comb begin
    release_grant = 1'b0;
    state_d       = state_q;
    case (state_q)
      IDLE: begin
        case (req)
          2'b01:   state_d = GRANT0;
          2'b10:   state_d = GRANT1;
          // Both requesting: the one not served last wins.
          2'b11:   state_d = last_served_q ? GRANT0 : GRANT1;
          default: state_d = IDLE;
        endcase
      end
      GRANT0: begin
        release_grant = (burst_cnt_q == MAX_CNT) || !req[0];
        if (release_grant) begin
          if (req[1])      state_d = GRANT1;
          else if (req[0]) state_d = GRANT0;
          else             state_d = IDLE;
        end
      end
      GRANT1: begin
        release_grant = (burst_cnt_q == MAX_CNT) || !req[1];
        if (release_grant) begin
          if (req[0])      state_d = GRANT0;
          else if (req[1]) state_d = GRANT1;
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= IDLE;
      s_q           <= 1'b0;
      f_q           <= '0;
      f_valid_q     <= 1'b0;
      burst_cnt_q   <= 4'd0;
      last_served_q <= 1'b1;
    end else begin
      state_q <= state_d;

      // The select follows the owner and holds its value through IDLE.
      if (state_d == GRANT1)      s_q <= 1'b1;
      else if (state_d == GRANT0) s_q <= 1'b0;

      // Release and accept are never in the same cycle. Release happens only
      // when the burst is full or the owner's req is low. Neither case allows
      // an ack.
      if (release_grant) begin
        last_served_q <= (state_q == GRANT1);
        burst_cnt_q   <= 4'd0;
      end else if (|ack) begin
        burst_cnt_q <= burst_cnt_q + 4'd1;
      end

      if (|ack) begin
        f_q       <= s_q ? w1 : w0;
        f_valid_q <= 1'b1;
      end else if (out_ready) begin
        f_valid_q <= 1'b0;
      end
    end
  end

  assign gnt       = state_q;
  assign s         = s_q;
  assign f         = f_q;
  assign f_valid   = f_valid_q;
  assign burst_cnt = burst_cnt_q;

endmodule
